// File: rtl/ins_sort8.sv
// Two-stage sorter: registers eight words, insertion-sorts them combinationally
// into descending order, registers the result. INS_SIGNED_EN selects signed compare.
module ins_sort8 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   input  logic [DATA_W-1:0] in5,
   input  logic [DATA_W-1:0] in6,
   input  logic [DATA_W-1:0] in7,
   input  logic [DATA_W-1:0] in8,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [DATA_W-1:0] out3,
   output logic [DATA_W-1:0] out4,
   output logic [DATA_W-1:0] out5,
   output logic [DATA_W-1:0] out6,
   output logic [DATA_W-1:0] out7,
   output logic [DATA_W-1:0] out8
);

   logic [7:0][DATA_W-1:0] s1;
   logic [7:0][DATA_W-1:0] srt;
   logic [7:0][DATA_W-1:0] outr;
   logic [DATA_W-1:0]      key;
   logic                   done;

   function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef INS_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   // Strict '>' means an equal key stops behind existing entries, keeping order stable.
   always_comb begin
      srt  = '0;
      key  = '0;
      done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         key  = s1[i];
         done = 1'b0;
         for (int j = 7; j >= 1; j--) begin
            if (j <= i && !done) begin
               if (gt(key, srt[j-1])) begin
                  srt[j] = srt[j-1];
               end else begin
                  srt[j] = key;
                  done   = 1'b1;
               end
            end
         end
         if (!done) srt[0] = key;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= '0;
         outr <= '0;
      end else begin
         s1   <= {in8, in7, in6, in5, in4, in3, in2, in1};
         outr <= srt;
      end
   end

   assign out1 = outr[0];
   assign out2 = outr[1];
   assign out3 = outr[2];
   assign out4 = outr[3];
   assign out5 = outr[4];
   assign out6 = outr[5];
   assign out7 = outr[6];
   assign out8 = outr[7];

endmodule

// File: tb/tb_ins_sort8.sv
// Directed and streaming checks for the two-cycle descending sorter ins_sort8.
module tb_ins_sort8;

   typedef logic [7:0][31:0] vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_a [8];
   logic [31:0] o1, o2, o3, o4, o5, o6, o7, o8;
   vec_t        outv;
   int          checks = 0;
   int          failures = 0;

   ins_sort8 #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .in1(in_a[0]), .in2(in_a[1]), .in3(in_a[2]), .in4(in_a[3]),
      .in5(in_a[4]), .in6(in_a[5]), .in7(in_a[6]), .in8(in_a[7]),
      .out1(o1), .out2(o2), .out3(o3), .out4(o4),
      .out5(o5), .out6(o6), .out7(o7), .out8(o8)
   );

   always #5 clk = ~clk;

   always_comb begin
      outv    = '0;
      outv[0] = o1; outv[1] = o2; outv[2] = o3; outv[3] = o4;
      outv[4] = o5; outv[5] = o6; outv[6] = o7; outv[7] = o8;
   end

   function automatic vec_t set8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
      vec_t v;
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
      v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
      return v;
   endfunction

   function automatic logic ref_gt(input logic [31:0] a, input logic [31:0] b);
`ifdef INS_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   // Selection sort: repeatedly pull the largest remaining word.
   function automatic vec_t ref_sort(input vec_t v);
      vec_t r;
      logic [7:0] used;
      int best;
      r = '0;
      used = '0;
      for (int k = 0; k < 8; k++) begin
         best = -1;
         for (int m = 0; m < 8; m++)
            if (!used[m] && (best < 0 || ref_gt(v[m], v[best]))) best = m;
         used[best] = 1'b1;
         r[k] = v[best];
      end
      return r;
   endfunction

   task automatic drive(input vec_t v);
      for (int i = 0; i < 8; i++) in_a[i] = v[i];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 8; i++) in_a[i] = $urandom;
         step();
      end
      checks++;
      if (outv !== '0) begin
         failures++;
         $display("FAIL reset_zero got=%h exp=0", outv);
      end
      rst = 1'b0;
      drive(set8(10, 20, 30, 40, 50, 60, 70, 80));
      step();
      checks++;
      if (outv !== '0) begin
         failures++;
         $display("FAIL reset_first_edge got=%h exp=0", outv);
      end
      step();
      checks++;
      if (outv !== set8(80, 70, 60, 50, 40, 30, 20, 10)) begin
         failures++;
         $display("FAIL reset_first_result got=%h exp=%h", outv, set8(80, 70, 60, 50, 40, 30, 20, 10));
      end
   endtask

   task automatic test_mixed();
      vec_t e;
      drive(set8(290, 255, 256, 270, 260, 258, 257, 300));
      step(); step();
      e = set8(300, 290, 270, 260, 258, 257, 256, 255);
      checks++;
      if (outv !== e) begin
         failures++;
         $display("FAIL mixed got=%h exp=%h", outv, e);
      end
   endtask

   task automatic test_dups();
      vec_t e1, e2;
      e1 = set8(93, 70, 64, 51, 42, 38, 25, 17);
      e2 = set8(70, 70, 50, 50, 50, 30, 30, 30);
      drive(set8(42, 17, 93, 25, 51, 38, 64, 70));
      step();
      drive(set8(50, 50, 30, 70, 30, 70, 50, 30));
      step();
      checks++;
      if (outv !== e1) begin
         failures++;
         $display("FAIL random_set got=%h exp=%h", outv, e1);
      end
      step();
      checks++;
      if (outv !== e2) begin
         failures++;
         $display("FAIL duplicates got=%h exp=%h", outv, e2);
      end
   endtask

   task automatic test_edges();
      vec_t e;
      drive(set8(25, 25, 25, 25, 25, 25, 25, 25));
      step(); step();
      e = set8(25, 25, 25, 25, 25, 25, 25, 25);
      checks++;
      if (outv !== e) begin
         failures++;
         $display("FAIL all_equal got=%h exp=%h", outv, e);
      end
      drive(set8(0, 255, 128, 64, 192, 32, 224, 16));
      step(); step();
      e = set8(255, 224, 192, 128, 64, 32, 16, 0);
      checks++;
      if (outv !== e) begin
         failures++;
         $display("FAIL edge_bytes got=%h exp=%h", outv, e);
      end
      drive(set8(5, 32'hFFFFFFFF, 0, 7, 32'h80000000, 3, 32'h7FFFFFFF, 1));
      step(); step();
`ifdef INS_SIGNED_EN
      e = set8(32'h7FFFFFFF, 7, 5, 3, 1, 0, 32'hFFFFFFFF, 32'h80000000);
`else
      e = set8(32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 7, 5, 3, 1, 0);
`endif
      checks++;
      if (outv !== e) begin
         failures++;
         $display("FAIL max_min got=%h exp=%h", outv, e);
      end
   endtask

   task automatic test_back_to_back();
      vec_t hist [20];
      vec_t v;
      for (int c = 0; c <= 20; c++) begin
         if (c < 20) begin
            for (int i = 0; i < 8; i++) v[i] = (i == c % 8) ? v[(i + 3) % 8] : $urandom;
            hist[c] = ref_sort(v);
            drive(v);
         end
         step();
         if (c >= 1) begin
            checks++;
            if (outv !== hist[c-1]) begin
               failures++;
               $display("FAIL stream_%0d got=%h exp=%h", c - 1, outv, hist[c-1]);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      vec_t z, w;
      drive(set8(1, 2, 3, 4, 5, 6, 7, 8));
      step();
      drive(set8(9, 9, 9, 9, 9, 9, 9, 9));
      rst = 1'b1;
      step();
      checks++;
      if (outv !== '0) begin
         failures++;
         $display("FAIL mid_reset_clear got=%h exp=0", outv);
      end
      rst = 1'b0;
      z = set8(3, 1, 4, 1, 5, 9, 2, 6);
      drive(z);
      step();
      checks++;
      if (outv !== '0) begin
         failures++;
         $display("FAIL mid_reset_flush got=%h exp=0", outv);
      end
      w = set8(100, 0, 50, 75, 25, 12, 88, 60);
      drive(w);
      step();
      checks++;
      if (outv !== set8(9, 6, 5, 4, 3, 2, 1, 1)) begin
         failures++;
         $display("FAIL mid_reset_resume got=%h exp=%h", outv, set8(9, 6, 5, 4, 3, 2, 1, 1));
      end
      step();
      checks++;
      if (outv !== set8(100, 88, 75, 60, 50, 25, 12, 0)) begin
         failures++;
         $display("FAIL mid_reset_next got=%h exp=%h", outv, set8(100, 88, 75, 60, 50, 25, 12, 0));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) in_a[i] = '0;
      test_reset();
      test_mixed();
      test_dups();
      test_edges();
      test_back_to_back();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ins_sort8.md
Name: ins_sort8

Overview:
- Pipelined sorter for eight unsigned DATA_W-bit words. Output order is descending: out1 is the largest value and out8 is the smallest.
- Fully combinational insertion-sort network placed between two register stages.
- Accepts a new 8-word set every clock cycle; latency is 2 cycles.
- Used as a drop-in sort stage in the datapath; no handshake.

Parameters:
- DATA_W, 32, width of each input and output word.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in1..in8  input  DATA_W each  unsorted operands, sampled every rising edge.
- out1..out8  output  DATA_W each  sorted result; out1 >= out2 >= … >= out8; registered.

Behaviour:
- Stage 1: at each rising edge, in1..in8 are captured into holding registers s1_0..s1_7.
- Sort network, combinational on s1_*:
  - Classic insertion sort over 8 slots: element i is inserted into the already-sorted prefix 0..i-1.
  - Comparison uses the ">" operator: a new element moves ahead of existing entries only if strictly greater.
  - Net effect on equal values: order is stable, and the multiset is preserved exactly.
  - Comparison is unsigned unless the optional feature is enabled.
- Stage 2: at each rising edge, the sorted vector is registered into out1..out8.
- Latency: operands present at rising edge k appear on out1..out8 immediately after rising edge k+1.
  - The outputs are valid for checking from then until the next edge.
- Throughput: one set per cycle. Back-to-back distinct sets stream without bubbles.
- Output is always a permutation of the sampled inputs: no value is lost, duplicated or altered.
- Reset:
  - When rst=1 at a rising edge, all stage-1 registers and out1..out8 become 0.
  - Reset has priority over data capture.
  - After rst deasserts, the first valid result appears 2 edges after the first non-reset sample.
  - Until then the outputs stay 0, which is trivially sorted.
- Reset mid-stream: in-flight sets are discarded, with no partial results.
- Boundary cases:
  - All-equal inputs: every output equals that value.
  - Inputs containing 0 and the maximum value (all ones): sorted without wrap or overflow.
- No X propagation from reset state; no internal FSM.
- Outputs change only on clock edges.

Optional Feature:
- Macro INS_SIGNED_EN.
  - Defined: all comparisons treat words as two's-complement signed. Example: 32'hFFFFFFFF (-1) sorts below 0.
  - Undefined (default): comparisons are unsigned, so 32'hFFFFFFFF is the largest value.
- Latency, ports and reset behaviour are identical in both builds.

Test Plan:
- Reset: assert rst for 3 cycles with random inputs -> out1..out8 all 0; deassert and drive 10,20,…,80 -> 2 edges later outputs are 80,70,60,50,40,30,20,10.
- Mixed values: 290,255,256,270,260,258,257,300 -> 300,290,270,260,258,257,256,255.
- Random set then duplicates:
  - Drive 42,17,93,25,51,38,64,70 -> 93,70,64,51,42,38,25,17.
  - Next drive 50,50,30,70,30,70,50,30 -> 70,70,50,50,50,30,30,30.
- All-equal then edge values:
  - Drive all 25 -> all 25.
  - Drive 0,255,128,64,192,32,224,16 -> 255,224,192,128,64,32,16,0.
  - Unsigned build only: drive 32'hFFFFFFFF and 0 among the words -> FFFFFFFF first, 0 last.
- Back-to-back streaming:
  - Change the inputs every cycle for 20 cycles with random data.
  - Each cycle, the outputs must be descending and a permutation of the set sampled 2 edges earlier.
  - Assert rst mid-stream -> outputs 0 on the next edge, then normal results resume 2 cycles after deassertion.
